// File: rtl/id_ex_alu_issue.sv
// id_ex_alu_issue
//   ID/EX issue register for a 32-bit MIPS subset. It decodes the incoming
//   instruction, selects ALU operands (with forwarding from the instruction
//   leaving the held slot), and holds the result for the execute stage. It
//   also detects load-use hazards and stalls issue for one cycle.
//
// Ports
//   clk          single clock, all state on rising edge
//   rst          asynchronous, active-high reset
//   in_valid     decoded-stage instruction valid
//   in_ready     issue accepts an instruction this cycle (combinational)
//   instr        MIPS instruction word
//   rs_data      register-file read of instr[25:21]
//   rt_data      register-file read of instr[20:16]
//   flush        kill the held instruction; also blocks a same-cycle accept
//   ex_ready     execute stage consumes the held instruction this cycle
//   alu_result   ALU result for the currently held operands
//   out_valid    held operands/control valid
//   alu_a/alu_b  ALU operands
//   alu_control  010 add, 110 sub, 000 and, 001 or, 111 slt
//   wr_reg       destination register
//   reg_write, mem_read, mem_write, branch   stage strobes
//   illegal      unsupported opcode/funct
//   load_use     load-use stall active (combinational)
//
// FSM states
//   state | meaning
//   RUN   | normal issue
//   STALL | one-cycle bubble after a load-use hazard; held load drains

module id_ex_alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  input  logic        ex_ready,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_control,
  output logic [4:0]  wr_reg,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        illegal,
  output logic        load_use
);

  typedef enum logic [0:0] {RUN, STALL} state_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t      r_state;
  logic        r_out_valid;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [2:0]  r_alu_control;
  logic [4:0]  r_wr_reg;
  logic        r_reg_write;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_branch;
  logic        r_illegal;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_sext;
  logic [31:0] w_zext;

  logic [2:0]  w_ctrl;
  logic        w_uses_rt;
  logic [31:0] w_imm_ext;
  logic [4:0]  w_wr_reg;
  logic        w_reg_write;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_branch;
  logic        w_illegal;

  logic        w_fwd_ok;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [31:0] w_b;
  logic        w_hazard;
  logic        w_accept;

  assign w_opcode = instr[31:26];
  assign w_rs     = instr[25:21];
  assign w_rt     = instr[20:16];
  assign w_rd     = instr[15:11];
  assign w_funct  = instr[5:0];
  assign w_sext   = {{16{instr[15]}}, instr[15:0]};
  assign w_zext   = {16'h0000, instr[15:0]};

  always_comb begin
    w_ctrl      = ALU_ADD;
    w_uses_rt   = 1'b0;
    w_imm_ext   = w_sext;
    w_wr_reg    = 5'd0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_branch    = 1'b0;
    w_illegal   = 1'b0;
    case (w_opcode)
      6'h00: begin
        w_uses_rt   = 1'b1;
        w_wr_reg    = w_rd;
        w_reg_write = 1'b1;
        case (w_funct)
          6'h20:   w_ctrl = ALU_ADD;
          6'h22:   w_ctrl = ALU_SUB;
          6'h24:   w_ctrl = ALU_AND;
          6'h25:   w_ctrl = ALU_OR;
          6'h2A:   w_ctrl = ALU_SLT;
          default: begin
            w_ctrl      = ALU_ADD;
            w_uses_rt   = 1'b0;
            w_wr_reg    = 5'd0;
            w_reg_write = 1'b0;
            w_illegal   = 1'b1;
          end
        endcase
      end
      6'h23: begin
        w_wr_reg    = w_rt;
        w_reg_write = 1'b1;
        w_mem_read  = 1'b1;
      end
      6'h2B: w_mem_write = 1'b1;
      6'h04: begin
        w_ctrl    = ALU_SUB;
        w_uses_rt = 1'b1;
        w_branch  = 1'b1;
      end
      6'h08: begin
        w_wr_reg    = w_rt;
        w_reg_write = 1'b1;
      end
      6'h0C: begin
        w_ctrl      = ALU_AND;
        w_imm_ext   = w_zext;
        w_wr_reg    = w_rt;
        w_reg_write = 1'b1;
      end
      6'h0D: begin
        w_ctrl      = ALU_OR;
        w_imm_ext   = w_zext;
        w_wr_reg    = w_rt;
        w_reg_write = 1'b1;
      end
      6'h0A: begin
        w_ctrl      = ALU_SLT;
        w_wr_reg    = w_rt;
        w_reg_write = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Forward only from a non-load producer that leaves the slot this cycle;
  // a load's data is not available yet, which is what the stall covers.
  assign w_fwd_ok = r_out_valid && ex_ready && r_reg_write && !r_mem_read &&
                    (r_wr_reg != 5'd0);
  assign w_rs_val = (w_fwd_ok && (w_rs == r_wr_reg)) ? alu_result : rs_data;
  assign w_rt_val = (w_fwd_ok && w_uses_rt && (w_rt == r_wr_reg)) ? alu_result : rt_data;
  assign w_b      = w_uses_rt ? w_rt_val : w_imm_ext;

  // Source register reads the pending load destination. r_wr_reg != 0 also
  // keeps $0 from ever stalling.
  assign w_hazard = (r_state == RUN) && in_valid && r_out_valid && r_mem_read &&
                    (r_wr_reg != 5'd0) &&
                    ((w_rs == r_wr_reg) || (w_uses_rt && (w_rt == r_wr_reg)));

  // The hazard also blocks acceptance in the detecting cycle so the consumer
  // stays on the input and is re-read from the register file after the stall.
  assign in_ready = (!r_out_valid || ex_ready) && (r_state == RUN) && !w_hazard;
  assign load_use = (r_state == STALL) || w_hazard;
  assign w_accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RUN;
      r_out_valid   <= 1'b0;
      r_alu_a       <= 32'd0;
      r_alu_b       <= 32'd0;
      r_alu_control <= ALU_ADD;
      r_wr_reg      <= 5'd0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_branch      <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      case (r_state)
        RUN:     if (w_hazard) r_state <= STALL;
        STALL:   r_state <= RUN;
        default: r_state <= RUN;
      endcase

      if (flush) begin
        r_out_valid <= 1'b0;
        r_reg_write <= 1'b0;
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        r_branch    <= 1'b0;
        r_illegal   <= 1'b0;
      end else if (w_accept) begin
        r_out_valid   <= 1'b1;
        r_alu_a       <= w_rs_val;
        r_alu_b       <= w_b;
        r_alu_control <= w_ctrl;
        r_wr_reg      <= w_wr_reg;
        r_reg_write   <= w_reg_write;
        r_mem_read    <= w_mem_read;
        r_mem_write   <= w_mem_write;
        r_branch      <= w_branch;
        r_illegal     <= w_illegal;
      end else if (r_out_valid && ex_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_control = r_alu_control;
  assign wr_reg      = r_wr_reg;
  assign reg_write   = r_reg_write;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign branch      = r_branch;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
module tb_id_ex_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        ex_ready;
  logic [31:0] alu_result;
  logic        out_valid;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_control;
  logic [4:0]  wr_reg;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        illegal;
  logic        load_use;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADD_3_1_2  = 32'h00221820;
  localparam logic [31:0] I_ORI_4_0    = 32'h34048000;
  localparam logic [31:0] I_ADDI_4_0   = 32'h20048000;
  localparam logic [31:0] I_SUB_5_1_2  = 32'h00222822;
  localparam logic [31:0] I_AND_6_5_5  = 32'h00A53024;
  localparam logic [31:0] I_ADD_0_1_2  = 32'h00220020;
  localparam logic [31:0] I_ADD_3_0_0  = 32'h00001820;
  localparam logic [31:0] I_LW_2_4_1   = 32'h8C220004;
  localparam logic [31:0] I_ADD_7_2_1  = 32'h00413820;
  localparam logic [31:0] I_SW_2_8_1   = 32'hAC220008;
  localparam logic [31:0] I_BEQ_1_2    = 32'h10220003;
  localparam logic [31:0] I_SLT_3_1_2  = 32'h0022182A;
  localparam logic [31:0] I_ILLEGAL    = 32'hFC000000;

  id_ex_alu_issue dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .flush       (flush),
    .ex_ready    (ex_ready),
    .alu_result  (alu_result),
    .out_valid   (out_valid),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .wr_reg      (wr_reg),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .branch      (branch),
    .illegal     (illegal),
    .load_use    (load_use)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    in_valid = 1'b1;
    instr    = i;
    rs_data  = rs;
    rt_data  = rt;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    instr      = 32'd0;
    rs_data    = 32'd0;
    rt_data    = 32'd0;
    flush      = 1'b0;
    ex_ready   = 1'b1;
    alu_result = 32'd0;

    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_ctrl", {29'd0, alu_control}, 32'd2);
    chk("rst_wr_reg", {27'd0, wr_reg}, 32'd0);
    chk("rst_strobes", {27'd0, reg_write, mem_read, mem_write, branch, illegal}, 32'd0);
    chk("rst_load_use", {31'd0, load_use}, 32'd0);
    tick();
    rst = 1'b0;

    // add $3,$1,$2
    drive(I_ADD_3_1_2, 32'd5, 32'd7);
    tick();
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_a", alu_a, 32'd5);
    chk("add_b", alu_b, 32'd7);
    chk("add_ctrl", {29'd0, alu_control}, 32'd2);
    chk("add_wr", {27'd0, wr_reg}, 32'd3);
    chk("add_rw", {31'd0, reg_write}, 32'd1);

    // ori zero-extends, addi sign-extends
    drive(I_ORI_4_0, 32'd0, 32'd0);
    tick();
    chk("ori_b", alu_b, 32'h00008000);
    chk("ori_ctrl", {29'd0, alu_control}, 32'd1);
    drive(I_ADDI_4_0, 32'd0, 32'd0);
    tick();
    chk("addi_b", alu_b, 32'hFFFF8000);
    chk("addi_ctrl", {29'd0, alu_control}, 32'd2);
    chk("addi_wr", {27'd0, wr_reg}, 32'd4);

    // sub $5 held, then and $6,$5,$5 forwards alu_result into both operands
    drive(I_SUB_5_1_2, 32'd9, 32'd4);
    tick();
    chk("sub_ctrl", {29'd0, alu_control}, 32'd6);
    chk("sub_wr", {27'd0, wr_reg}, 32'd5);
    drive(I_AND_6_5_5, 32'hDEAD, 32'hDEAD);
    alu_result = 32'h11;
    tick();
    chk("fwd_a", alu_a, 32'h11);
    chk("fwd_b", alu_b, 32'h11);
    chk("and_ctrl", {29'd0, alu_control}, 32'd0);

    // $0 is never forwarded
    drive(I_ADD_0_1_2, 32'd1, 32'd2);
    tick();
    drive(I_ADD_3_0_0, 32'd0, 32'd0);
    alu_result = 32'h99;
    tick();
    chk("r0_nofwd_a", alu_a, 32'd0);
    chk("r0_nofwd_b", alu_b, 32'd0);

    // lw $2 then add $7,$2,$1: one stall, consumer re-read from regfile
    drive(I_LW_2_4_1, 32'h100, 32'd0);
    tick();
    chk("lw_mr", {31'd0, mem_read}, 32'd1);
    chk("lw_b", alu_b, 32'd4);
    chk("lw_a", alu_a, 32'h100);
    chk("lw_wr", {27'd0, wr_reg}, 32'd2);
    ex_ready   = 1'b0;
    alu_result = 32'h77;
    drive(I_ADD_7_2_1, 32'h55, 32'h66);
    #1;
    chk("lu_detect_load_use", {31'd0, load_use}, 32'd1);
    chk("lu_detect_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("lu_stall_load_use", {31'd0, load_use}, 32'd1);
    chk("lu_stall_in_ready", {31'd0, in_ready}, 32'd0);
    chk("lu_stall_held_wr", {27'd0, wr_reg}, 32'd2);
    ex_ready = 1'b1;
    #1;
    chk("lu_drain_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("lu_after_valid", {31'd0, out_valid}, 32'd0);
    chk("lu_after_load_use", {31'd0, load_use}, 32'd0);
    chk("lu_after_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("lu_cons_a", alu_a, 32'h55);
    chk("lu_cons_b", alu_b, 32'h66);
    chk("lu_cons_wr", {27'd0, wr_reg}, 32'd7);
    chk("lu_cons_valid", {31'd0, out_valid}, 32'd1);

    // flush wins over a same-cycle accept
    flush = 1'b1;
    drive(I_SW_2_8_1, 32'd1, 32'd2);
    tick();
    flush = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);

    // illegal opcode
    drive(I_ILLEGAL, 32'd1, 32'd2);
    tick();
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_strobes", {28'd0, reg_write, mem_read, mem_write, branch}, 32'd0);
    chk("ill_valid", {31'd0, out_valid}, 32'd1);
    chk("ill_ctrl", {29'd0, alu_control}, 32'd2);
    chk("ill_wr", {27'd0, wr_reg}, 32'd0);

    // sw, beq, slt
    drive(I_SW_2_8_1, 32'd1, 32'd2);
    tick();
    chk("sw_mw", {31'd0, mem_write}, 32'd1);
    chk("sw_rw", {31'd0, reg_write}, 32'd0);
    chk("sw_b", alu_b, 32'd8);
    drive(I_BEQ_1_2, 32'd3, 32'd4);
    tick();
    chk("beq_br", {31'd0, branch}, 32'd1);
    chk("beq_ctrl", {29'd0, alu_control}, 32'd6);
    chk("beq_b", alu_b, 32'd4);
    drive(I_SLT_3_1_2, 32'd3, 32'd4);
    tick();
    chk("slt_ctrl", {29'd0, alu_control}, 32'd7);

    // backpressure: held instruction stays, no accept
    ex_ready = 1'b0;
    drive(I_ADD_3_1_2, 32'd5, 32'd7);
    #1;
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bp_hold_ctrl", {29'd0, alu_control}, 32'd7);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);

    // reset in the middle of a stall
    ex_ready = 1'b1;
    drive(I_LW_2_4_1, 32'h100, 32'd0);
    tick();
    ex_ready = 1'b0;
    drive(I_ADD_7_2_1, 32'h55, 32'h66);
    tick();
    chk("rs_pre_stall", {31'd0, load_use}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rs_valid", {31'd0, out_valid}, 32'd0);
    chk("rs_load_use", {31'd0, load_use}, 32'd0);
    chk("rs_strobes", {27'd0, reg_write, mem_read, mem_write, branch, illegal}, 32'd0);
    chk("rs_a", alu_a, 32'd0);
    chk("rs_in_ready", {31'd0, in_ready}, 32'd1);
    #1;
    rst      = 1'b0;
    ex_ready = 1'b1;
    drive(I_ADD_3_1_2, 32'd5, 32'd7);
    tick();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_a", alu_a, 32'd5);
    chk("post_rst_wr", {27'd0, wr_reg}, 32'd3);

    in_valid = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
